// File: rtl/tube_pkg.sv
// Shared Tube definitions: FIFO geometry and 2-bit Gray conversion helpers
// used by the register FIFOs that cross the host/parasite boundary.
package tube_pkg;

  localparam int TUBE_FIFO_DEPTH = 2;
  localparam int TUBE_PTR_W      = 2;

  function automatic logic [TUBE_PTR_W-1:0] bin2gray(input logic [TUBE_PTR_W-1:0] bin);
    return {bin[1], bin[1] ^ bin[0]};
  endfunction

  function automatic logic [TUBE_PTR_W-1:0] gray2bin(input logic [TUBE_PTR_W-1:0] gray);
    return {gray[1], gray[1] ^ gray[0]};
  endfunction

endpackage

// File: rtl/tube_sync2.sv
// Two-flop falling-edge synchronizer, any width. Only Gray-coded or
// quasi-static values may pass through it.
module tube_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // next-state for the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer stages, cleared asynchronously
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hp_reg3_fifo.sv
// Tube register 3 host-to-parasite FIFO: two entries written on h_phi2 and
// read on p_phi2. Each side judges full/available from a synchronized view.
module hp_reg3_fifo
  import tube_pkg::*;
#(
  parameter int         DEPTH    = TUBE_FIFO_DEPTH,
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input  logic       h_phi2,
  input  logic       p_phi2,
  input  logic       h_rst_b,
  input  logic [7:0] h_data,
  input  logic       h_selectData,
  input  logic       h_rdnw,
  input  logic       h_two_byte_mode,
  input  logic       p_selectData,
  input  logic       p_rdnw,
  output logic [7:0] p_data,
  output logic       p_data_available,
  output logic       p_nmi,
  output logic       h_full
);

  logic [7:0]            mem_q [0:DEPTH-1];
  logic [7:0]            mem_d [0:DEPTH-1];
  logic [TUBE_PTR_W-1:0] wp_q, wp_d, wp_gray_q, wp_gray_d;
  logic [TUBE_PTR_W-1:0] rp_q, rp_d, rp_gray_q, rp_gray_d;
  logic [TUBE_PTR_W-1:0] rp_gray_hsync, rp_hsync_bin, hcount;
  logic [TUBE_PTR_W-1:0] wp_gray_psync, wp_psync_bin, pcount;
  logic                  mode_sync;
  logic                  h_wr_en, p_rd_en;

  // Host view: the write pointer is exact, the read pointer may lag.
  assign rp_hsync_bin = gray2bin(rp_gray_hsync);
  assign hcount       = wp_q - rp_hsync_bin;
  assign h_wr_en      = h_selectData & ~h_rdnw & ~h_full;

  // host full flag, threshold chosen by the mode bit
  always_comb begin
    if (h_two_byte_mode) begin
      h_full = (hcount == 2'd2);
    end else begin
      h_full = (hcount != 2'd0);
    end
  end

  // host write: store at the address bit, then advance the pointer
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (h_wr_en) begin
      mem_d[wp_q[0]] = h_data;
      wp_d           = wp_q + 2'd1;
    end else begin
      wp_d           = wp_q;
    end
    wp_gray_d = bin2gray(wp_d);
  end

  // host-domain state; Gray copy is registered so it never glitches
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_DATA;
      end
      wp_q      <= 2'd0;
      wp_gray_q <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q      <= wp_d;
      wp_gray_q <= wp_gray_d;
    end
  end

  tube_sync2 #(.W(TUBE_PTR_W)) u_rp_to_host (
    .clk   (h_phi2),
    .rst_b (h_rst_b),
    .d     (rp_gray_q),
    .q     (rp_gray_hsync)
  );

  tube_sync2 #(.W(TUBE_PTR_W)) u_wp_to_para (
    .clk   (p_phi2),
    .rst_b (h_rst_b),
    .d     (wp_gray_q),
    .q     (wp_gray_psync)
  );

  tube_sync2 #(.W(1)) u_mode_to_para (
    .clk   (p_phi2),
    .rst_b (h_rst_b),
    .d     (h_two_byte_mode),
    .q     (mode_sync)
  );

  // Parasite view: the read pointer is exact, the write pointer may lag.
  assign wp_psync_bin     = gray2bin(wp_gray_psync);
  assign pcount           = wp_psync_bin - rp_q;
  assign p_data_available = (pcount != 2'd0);
  assign p_rd_en          = p_selectData & p_rdnw & p_data_available;
  assign p_data           = mem_q[rp_q[0]];

  // parasite attention, threshold chosen by the synchronized mode bit
  always_comb begin
    if (mode_sync) begin
      p_nmi = (pcount == 2'd2);
    end else begin
      p_nmi = (pcount != 2'd0);
    end
  end

  // parasite read pointer advance
  always_comb begin
    if (p_rd_en) begin
      rp_d = rp_q + 2'd1;
    end else begin
      rp_d = rp_q;
    end
    rp_gray_d = bin2gray(rp_d);
  end

  // parasite-domain state
  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rp_q      <= 2'd0;
      rp_gray_q <= 2'd0;
    end else begin
      rp_q      <= rp_d;
      rp_gray_q <= rp_gray_d;
    end
  end

endmodule
